// File: rtl/dispenser_pkg.sv
// Shared types and stage-ordering helper for the drink dispenser.
package dispenser_pkg;

   typedef enum logic [2:0] {IDLE, WATER, COFFEE, CHOC, MILK, SUGAR, DONE} state_t;

   typedef logic [4:0] ingredient_mask_t;

   localparam int unsigned ING_WATER  = 0;
   localparam int unsigned ING_COFFEE = 1;
   localparam int unsigned ING_CHOC   = 2;
   localparam int unsigned ING_MILK   = 3;
   localparam int unsigned ING_SUGAR  = 4;

   // First selected stage strictly after cur in water→coffee→choc→milk→sugar order, else DONE.
   function automatic state_t next_stage(input state_t cur, input ingredient_mask_t mask);
      ingredient_mask_t later;
      ingredient_mask_t avail;
      state_t           nxt;
      case (cur)
         IDLE:    later = 5'b11111;
         WATER:   later = 5'b11110;
         COFFEE:  later = 5'b11100;
         CHOC:    later = 5'b11000;
         MILK:    later = 5'b10000;
         default: later = '0;
      endcase
      avail = mask & later;
      nxt   = DONE;
      if (avail[ING_SUGAR])  nxt = SUGAR;
      if (avail[ING_MILK])   nxt = MILK;
      if (avail[ING_CHOC])   nxt = CHOC;
      if (avail[ING_COFFEE]) nxt = COFFEE;
      if (avail[ING_WATER])  nxt = WATER;
      return nxt;
   endfunction

endpackage

// File: rtl/stage_timer.sv
// Loadable down-counter timing one dispense stage; expire_o flags a zero count.
module stage_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             expire_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/drink_dispenser.sv
// Latches an ingredient request and opens each selected valve in turn for a fixed duration.
module drink_dispenser
   import dispenser_pkg::*;
#(
   parameter int unsigned WATER_CYCLES  = 8,
   parameter int unsigned COFFEE_CYCLES = 4,
   parameter int unsigned CHOC_CYCLES   = 3,
   parameter int unsigned MILK_CYCLES   = 4,
   parameter int unsigned SUGAR_CYCLES  = 2,
   parameter int unsigned CNT_W         = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic water_req,
   input  logic coffee_req,
   input  logic sugar_req,
   input  logic milk_req,
   input  logic chocolate_req,
   output logic valve_water,
   output logic valve_coffee,
   output logic valve_chocolate,
   output logic valve_milk,
   output logic valve_sugar,
   output logic busy,
   output logic done,
   output logic error
);

   localparam longint unsigned MAX_CYC = 64'(1) << CNT_W;

   if (WATER_CYCLES == 0 || COFFEE_CYCLES == 0 || CHOC_CYCLES == 0 ||
       MILK_CYCLES == 0 || SUGAR_CYCLES == 0 ||
       WATER_CYCLES > MAX_CYC || COFFEE_CYCLES > MAX_CYC || CHOC_CYCLES > MAX_CYC ||
       MILK_CYCLES > MAX_CYC || SUGAR_CYCLES > MAX_CYC) begin : g_bad_cycles
      $fatal(1, "drink_dispenser: every *_CYCLES must be in 1..2**CNT_W");
   end

   state_t           state_q, state_d;
   ingredient_mask_t mask_q, mask_d;
   ingredient_mask_t req;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             expire;
   logic             err_d;
   logic             vw_q, vc_q, vch_q, vm_q, vs_q, busy_q, done_q, err_q;

   assign req = {sugar_req, milk_req, chocolate_req, coffee_req, water_req};

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      load    = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (req != '0) begin
                  mask_d  = req;
                  state_d = next_stage(IDLE, req);
                  load    = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         DONE: state_d = IDLE;
         default: begin
            if (expire) begin
               state_d = next_stage(state_q, mask_q);
               load    = 1'b1;
            end
         end
      endcase
   end

   // Reload value follows the stage being entered so there is no gap cycle between stages.
   always_comb begin
      case (state_d)
         WATER:   load_val = CNT_W'(WATER_CYCLES - 1);
         COFFEE:  load_val = CNT_W'(COFFEE_CYCLES - 1);
         CHOC:    load_val = CNT_W'(CHOC_CYCLES - 1);
         MILK:    load_val = CNT_W'(MILK_CYCLES - 1);
         SUGAR:   load_val = CNT_W'(SUGAR_CYCLES - 1);
         default: load_val = '0;
      endcase
   end

   stage_timer #(.CNT_W(CNT_W)) u_timer (
      .clk_i      (clock),
      .rst_i      (reset),
      .load_i     (load),
      .load_val_i (load_val),
      .expire_o   (expire)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         mask_q  <= '0;
         vw_q    <= 1'b0;
         vc_q    <= 1'b0;
         vch_q   <= 1'b0;
         vm_q    <= 1'b0;
         vs_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         vw_q    <= (state_d == WATER);
         vc_q    <= (state_d == COFFEE);
         vch_q   <= (state_d == CHOC);
         vm_q    <= (state_d == MILK);
         vs_q    <= (state_d == SUGAR);
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
         err_q   <= err_d;
      end
   end

   assign valve_water     = vw_q;
   assign valve_coffee    = vc_q;
   assign valve_chocolate = vch_q;
   assign valve_milk      = vm_q;
   assign valve_sugar     = vs_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = err_q;

endmodule

// File: tb/tb_drink_dispenser.sv
// Scoreboard bench for drink_dispenser: expected dispense profiles are queued, a monitor checks each one.
module tb_drink_dispenser;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic water_req = 1'b0, coffee_req = 1'b0, sugar_req = 1'b0, milk_req = 1'b0, chocolate_req = 1'b0;
   logic valve_water, valve_coffee, valve_chocolate, valve_milk, valve_sugar;
   logic busy, done, error;

   drink_dispenser #(
      .WATER_CYCLES  (8),
      .COFFEE_CYCLES (4),
      .CHOC_CYCLES   (3),
      .MILK_CYCLES   (4),
      .SUGAR_CYCLES  (2),
      .CNT_W         (8)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .water_req       (water_req),
      .coffee_req      (coffee_req),
      .sugar_req       (sugar_req),
      .milk_req        (milk_req),
      .chocolate_req   (chocolate_req),
      .valve_water     (valve_water),
      .valve_coffee    (valve_coffee),
      .valve_chocolate (valve_chocolate),
      .valve_milk      (valve_milk),
      .valve_sugar     (valve_sugar),
      .busy            (busy),
      .done            (done),
      .error           (error)
   );

   always #5 clock = ~clock;

   // Valve index order: 0 water, 1 coffee, 2 chocolate, 3 milk, 4 sugar; first = -1 when never opened.
   typedef struct packed {
      bit              is_err;
      logic [4:0][31:0] first;
      logic [4:0][31:0] len;
      int              done_at;
      int              busy_len;
   } exp_t;

   exp_t exp_q[$];
   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic push_exp(input bit is_err,
                           input int fw, input int lw, input int fc, input int lc,
                           input int fch, input int lch, input int fm, input int lm,
                           input int fs, input int ls, input int dn, input int bz);
      exp_t e;
      e.is_err   = is_err;
      e.first[0] = fw;  e.len[0] = lw;
      e.first[1] = fc;  e.len[1] = lc;
      e.first[2] = fch; e.len[2] = lch;
      e.first[3] = fm;  e.len[3] = lm;
      e.first[4] = fs;  e.len[4] = ls;
      e.done_at  = dn;
      e.busy_len = bz;
      exp_q.push_back(e);
   endtask

   // mask bits: {sugar, milk, chocolate, coffee, water}
   task automatic set_req(input logic [4:0] m);
      water_req     = m[0];
      coffee_req    = m[1];
      chocolate_req = m[2];
      milk_req      = m[3];
      sugar_req     = m[4];
   endtask

   task automatic issue(input logic [4:0] m);
      @(posedge clock); #1;
      start = 1'b1;
      set_req(m);
      @(posedge clock); #1;
      start = 1'b0;
      set_req(5'b0);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clock);
         n++;
      end
      chk("drain_timeout", exp_q.size(), 0);
      repeat (2) @(posedge clock);
   endtask

   // ---------------- monitor ----------------
   logic [4:0] vv, prev_v;
   bit   in_sess = 0, err_prev = 0, overlap = 0, gap = 0;
   int   cyc = 0, done_cnt = 0, done_at = -1;
   int   act_first[5], act_len[5];

   assign vv = {valve_sugar, valve_milk, valve_chocolate, valve_coffee, valve_water};

   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         in_sess  = 0;
         err_prev = 0;
      end else begin
         if (error) begin
            chk("error_single_cycle", int'(err_prev), 0);
            chk("error_busy", int'(busy), 0);
            chk("error_valves", int'(vv), 0);
            if (exp_q.size() == 0) begin
               chk("unexpected_error", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("error_expected", 1, int'(e.is_err));
            end
         end
         err_prev = error;
         if (busy) begin
            if (!in_sess) begin
               in_sess = 1; cyc = 0; overlap = 0; gap = 0; done_cnt = 0; done_at = -1; prev_v = '0;
               for (int i = 0; i < 5; i++) begin act_first[i] = -1; act_len[i] = 0; end
            end
            if ($countones(vv) > 1) overlap = 1;
            for (int i = 0; i < 5; i++) begin
               if (vv[i]) begin
                  if (act_len[i] == 0) act_first[i] = cyc;
                  else if (!prev_v[i]) gap = 1;
                  act_len[i]++;
               end
            end
            if (done) begin done_cnt++; done_at = cyc; end
            prev_v = vv;
            cyc++;
         end else if (in_sess) begin
            in_sess = 0;
            if (exp_q.size() == 0) begin
               chk("unexpected_dispense", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("dispense_expected", int'(e.is_err), 0);
               for (int i = 0; i < 5; i++) begin
                  chk($sformatf("valve%0d_first", i), act_first[i], int'(e.first[i]));
                  chk($sformatf("valve%0d_len", i), act_len[i], int'(e.len[i]));
               end
               chk("done_at", done_at, e.done_at);
               chk("done_count", done_cnt, 1);
               chk("busy_len", cyc, e.busy_len);
               chk("no_overlap", int'(overlap), 0);
               chk("no_gap", int'(gap), 0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      #3;
      chk("rst_busy", int'(busy), 0);
      chk("rst_valves", int'(vv), 0);
      chk("rst_done_err", int'({done, error}), 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Asynchronous reset mid-WATER; this dispense is abandoned so nothing is queued for it.
      issue(5'b00001);
      repeat (2) @(posedge clock);
      #1 chk("pre_reset_water", int'(valve_water), 1);
      #1 reset = 1'b1;
      #1;
      chk("async_reset_water", int'(valve_water), 0);
      chk("async_reset_busy", int'(busy), 0);
      @(negedge clock);
      @(posedge clock); #1 reset = 1'b0;

      // Espresso
      push_exp(0, 0, 8, 8, 4, -1, 0, -1, 0, -1, 0, 12, 13);
      issue(5'b00011);
      wait_drain(60);

      // Full mask
      push_exp(0, 0, 8, 8, 4, 12, 3, 15, 4, 19, 2, 21, 22);
      issue(5'b11111);
      wait_drain(60);

      // Sugar only
      push_exp(0, -1, 0, -1, 0, -1, 0, -1, 0, 0, 2, 2, 3);
      issue(5'b10000);
      wait_drain(60);

      // Empty mask
      push_exp(1, -1, 0, -1, 0, -1, 0, -1, 0, -1, 0, 0, 0);
      issue(5'b00000);
      wait_drain(20);
      chk("empty_no_busy", int'(busy), 0);

      // Chocolate + milk, water + sugar
      push_exp(0, -1, 0, -1, 0, 0, 3, 3, 4, -1, 0, 7, 8);
      issue(5'b01100);
      wait_drain(60);
      push_exp(0, 0, 8, -1, 0, -1, 0, -1, 0, 8, 2, 10, 11);
      issue(5'b10001);
      wait_drain(60);

      // start held through the whole dispense with changed requests must not retrigger
      push_exp(0, -1, 0, 0, 4, 4, 3, -1, 0, -1, 0, 7, 8);
      @(posedge clock); #1;
      start = 1'b1;
      set_req(5'b00110);
      @(posedge clock); #1;
      set_req(5'b01001);
      begin
         int n = 0;
         while (!done && n < 50) begin
            @(negedge clock);
            n++;
         end
         chk("held_done_seen", int'(done), 1);
      end
      @(posedge clock); #1;
      start = 1'b0;
      set_req(5'b0);
      repeat (4) begin
         @(negedge clock);
         chk("held_no_retrigger", int'(busy), 0);
      end
      wait_drain(20);

      push_exp(0, 0, 8, -1, 0, -1, 0, 8, 4, -1, 0, 12, 13);
      issue(5'b01001);
      wait_drain(60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/drink_dispenser.md
Name: drink_dispenser

Overview:
Responder to the coffee_machine request outputs. It latches a one-cycle ingredient request (water, coffee, sugar, milk, chocolate) and sequences the physical valves one at a time for fixed parameterised durations. It reports busy while dispensing and pulses done when the drink is finished. It sits between the coffee_machine controller and the valve drivers on the FPGA board.

Parameters:
WATER_CYCLES, 8, cycles valve_water stays open (must be >= 1)
COFFEE_CYCLES, 4, cycles valve_coffee stays open (must be >= 1)
CHOC_CYCLES, 3, cycles valve_chocolate stays open (must be >= 1)
MILK_CYCLES, 4, cycles valve_milk stays open (must be >= 1)
SUGAR_CYCLES, 2, cycles valve_sugar stays open (must be >= 1)
CNT_W, 8, stage counter width; every *_CYCLES value must be <= 2**CNT_W

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request strobe, sampled only in IDLE
water_req  in  1  ingredient select
coffee_req  in  1  ingredient select
sugar_req  in  1  ingredient select
milk_req  in  1  ingredient select
chocolate_req  in  1  ingredient select
valve_water  out  1  water valve open
valve_coffee  out  1  coffee valve open
valve_chocolate  out  1  chocolate valve open
valve_milk  out  1  milk valve open
valve_sugar  out  1  sugar valve open
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of dispense
error  out  1  one-cycle pulse when start arrives with an empty mask

Behaviour:
- Reset: one clock, clock; asynchronous active-high reset, reset. It forces state IDLE, latched mask 0, counter 0, all valves/busy/done/error 0, immediately and without waiting for a clock edge. Reset mid-dispense closes every valve at once and loses the request.
- States: IDLE, WATER, COFFEE, CHOC, MILK, SUGAR, DONE. Fixed stage order is water, coffee, chocolate, milk, sugar.
- Valves, busy and done are Moore outputs decoded from the registered state. A valve is high only in its own state. At most one valve is high in any cycle.
- IDLE:
  - When start=1 at edge t0 with a non-empty mask, the FSM latches the mask and enters the first selected stage. The counter loads that stage's *_CYCLES-1, so the valve is high from t0 onward.
  - When start=1 with an all-zero mask, the FSM stays in IDLE and error=1 for the cycle after t0.
- Stage: the counter decrements each edge. At the edge where the counter is 0, the FSM moves to the next selected stage (counter reloads) or to DONE. There is no gap cycle between stages.
- Each valve is high for exactly its *_CYCLES consecutive cycles.
- DONE: done=1 and busy=1 for exactly one cycle, then the FSM returns to IDLE.
- Total busy cycles = sum of the selected *_CYCLES + 1.
- While busy, start and the request inputs are ignored. The latched mask is the only source of truth, and requests are never queued.
- start=1 in the same cycle the FSM returns from DONE to IDLE is ignored. start is only accepted when the FSM was in IDLE before the edge.
- Unselected stages are skipped entirely and consume zero cycles.
- Parameter checks at elaboration: any *_CYCLES of 0, or any value above 2**CNT_W, is a fatal error.

Decomposition:
- dispenser_pkg holds:
  - state enum typedef (IDLE..DONE);
  - 5-bit ingredient_mask_t typedef;
  - bit-index constants ING_WATER=0, ING_COFFEE=1, ING_CHOC=2, ING_MILK=3, ING_SUGAR=4.
- One sub-module, stage_timer:
  - CNT_W down-counter with load value, load strobe, and an expire flag (count==0).
  - Instantiated once; the FSM drives load and consumes expire.
- Next-stage selection is a priority function in the package: given the current stage and the mask, it returns the next stage.

Test Plan:
1. Reset asserted asynchronously mid-WATER (between edges) -> valve_water and busy drop to 0 before the next edge; the next start behaves normally.
2. Espresso, water_req=coffee_req=1, start at t0 -> valve_water cycles 0-7, valve_coffee 8-11, done at cycle 12, busy for 13 cycles.
3. Full mask (all 5) at default parameters:
   - valve_water 0-7, coffee 8-11, chocolate 12-14, milk 15-18, sugar 19-20;
   - done at 21; no overlapping valves.
4. Sugar only -> valve_sugar cycles 0-1, done at 2, no other valve ever high.
5. Empty mask with start=1 -> error=1 for one cycle, busy stays 0, no valve opens.
6. A second start held high throughout a dispense, including the DONE cycle -> no second dispense. A new start after IDLE is reached gives a new dispense with the new mask.
